nonblocking_swap: RTL and testbench

//  - Two-register swap cell demonstrating non-blocking update semantics.
//  - Loads a_i/b_i into output registers, then exchanges them every clock (a_o<=b_o, b_o<=a_o).
//  - Optional periodic reload from the inputs.
//  - Used as a small datapath/teaching primitive and as a regression target for simulator scheduling.

---
 rtl/nonblocking_swap_pkg.sv | 21 ++
 rtl/nb_swap_pair.sv | 30 +++
 rtl/nonblocking_swap.sv | 95 +++++++++
 tb/tb_nonblocking_swap.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonblocking_swap_pkg.sv
// Shared types and defaults for the nonblocking_swap cell and its register pair.
// The state encoding is fixed so that it matches the legacy LOAD=0 / SWAP=1 values.
package nonblocking_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    SWAP = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 8;

  // True when a reload period fits in a counter of cnt_w bits (0 always fits).
  function automatic bit period_fits(input int unsigned period, input int unsigned cnt_w);
    longint unsigned limit;
    if (cnt_w >= 32) return 1'b1;
    limit = longint'(1) << cnt_w;
    return longint'(period) < limit;
  endfunction

endpackage

// File: rtl/nb_swap_pair.sv
// Two WIDTH-bit registers that either load from their inputs or exchange contents.
// Both registers sample pre-edge values, so a swap is a true exchange.
module nb_swap_pair
  import nonblocking_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_o <= '0;
      b_o <= '0;
    end else if (load) begin
      a_o <= a_i;
      b_o <= b_i;
    end else begin
      a_o <= b_o;
      b_o <= a_o;
    end
  end

endmodule

// File: rtl/nonblocking_swap.sv
// Swap cell: loads a_i/b_i once after reset, then exchanges a_o/b_o every clock,
// optionally reloading every RELOAD_PERIOD swaps. Define NONBLOCKING_SWAP_CNT_EN to expose swap_cnt.
module nonblocking_swap
  import nonblocking_pkg::*;
#(
  parameter int unsigned WIDTH         = DEFAULT_WIDTH,
  parameter int unsigned RELOAD_PERIOD = 0,
  parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
`ifdef NONBLOCKING_SWAP_CNT_EN
  ,
  output logic [CNT_W-1:0] swap_cnt
`endif
);

  // rst_n is active-high despite its name; it is kept for drop-in compatibility.
`ifdef NONBLOCKING_SWAP_CNT_EN
  localparam bit CNT_NEEDED = 1'b1;
`else
  localparam bit CNT_NEEDED = (RELOAD_PERIOD != 0);
`endif
  localparam logic [CNT_W-1:0] RELOAD_LAST = CNT_W'(RELOAD_PERIOD - 1);

  if (!period_fits(RELOAD_PERIOD, CNT_W)) begin : g_bad_period
    $error("nonblocking_swap: RELOAD_PERIOD must be below 2**CNT_W");
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             reload_hit;

  always_comb begin
    reload_hit = (RELOAD_PERIOD != 0) && (cnt_q == RELOAD_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (state_q == LOAD) begin
      state_d = SWAP;
    end else if (reload_hit) begin
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Without a reload period or a count port the counter has no observer, so it is tied off.
  if (CNT_NEEDED) begin : g_cnt
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        cnt_q <= '0;
      end else if (state_q == LOAD) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end else begin : g_no_cnt
    always_comb begin
      cnt_q = '0;
    end
  end

`ifdef NONBLOCKING_SWAP_CNT_EN
  always_comb begin
    swap_cnt = cnt_q;
  end
`endif

  nb_swap_pair #(
    .WIDTH(WIDTH)
  ) u_pair (
    .clk (clk),
    .rst (rst_n),
    .load(state_q == LOAD),
    .a_i (a_i),
    .b_i (b_i),
    .a_o (a_o),
    .b_o (b_o)
  );

endmodule

// File: tb/tb_nonblocking_swap.sv
// Scoreboard bench for nonblocking_swap: dut1 is WIDTH=1 without reload, dut2 is WIDTH=4 reloading every 3 swaps.
module tb_nonblocking_swap;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic [0:0] a1, b1, a1_o, b1_o;
  logic [3:0] a2, b2, a2_o, b2_o;
  logic [7:0] cnt1, cnt2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #10 clk = ~clk;

  nonblocking_swap #(.WIDTH(1), .RELOAD_PERIOD(0), .CNT_W(8)) dut1 (
    .clk  (clk),
    .rst_n(rst1),
    .a_i  (a1),
    .b_i  (b1),
    .a_o  (a1_o),
    .b_o  (b1_o)
`ifdef NONBLOCKING_SWAP_CNT_EN
    ,
    .swap_cnt(cnt1)
`endif
  );

  nonblocking_swap #(.WIDTH(4), .RELOAD_PERIOD(3), .CNT_W(8)) dut2 (
    .clk  (clk),
    .rst_n(rst2),
    .a_i  (a2),
    .b_i  (b2),
    .a_o  (a2_o),
    .b_o  (b2_o)
`ifdef NONBLOCKING_SWAP_CNT_EN
    ,
    .swap_cnt(cnt2)
`endif
  );

`ifndef NONBLOCKING_SWAP_CNT_EN
  always_comb begin
    cnt1 = '0;
    cnt2 = '0;
  end
`endif

  task automatic push1(input logic [3:0] a, input logic [3:0] b, input logic [7:0] cnt);
    exp_t x;
    x.a = a; x.b = b; x.cnt = cnt;
    q1.push_back(x);
  endtask

  task automatic push2(input logic [3:0] a, input logic [3:0] b, input logic [7:0] cnt);
    exp_t x;
    x.a = a; x.b = b; x.cnt = cnt;
    q2.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    a2 = 4'd5; b2 = 4'd9;
    #1;
    n_run++;
    if ({a1_o, b1_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_dut1: got (%0b,%0b) required (0,0)", a1_o, b1_o);
    end
    n_run++;
    if ({a2_o, b2_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dut2: got (%0d,%0d) required (0,0)", a2_o, b2_o);
    end
`ifdef NONBLOCKING_SWAP_CNT_EN
    n_run++;
    if (cnt1 !== 8'd0 || cnt2 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got (%0d,%0d) required (0,0)", cnt1, cnt2);
    end
`endif
    #4 rst1 = 1'b0;
  endtask

  task automatic test_load();
    push1(4'd1, 4'd0, 8'd0);
    tick();
    if (q1.size() == 0) begin
      n_run++; n_fail++;
      $display("FAIL load: scoreboard empty");
    end else begin
      e = q1.pop_front();
      n_run++;
      if (a1_o !== e.a[0] || b1_o !== e.b[0]) begin
        n_fail++;
        $display("FAIL load: got (%0b,%0b) required (%0b,%0b)", a1_o, b1_o, e.a[0], e.b[0]);
      end
    end
    n_run++;
    if ({a2_o, b2_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: got (%0d,%0d) required (0,0)", a2_o, b2_o);
    end
  endtask

  task automatic test_swap();
    push1(4'd0, 4'd1, 8'd1);
    push1(4'd1, 4'd0, 8'd2);
    push1(4'd0, 4'd1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (q1.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL swap[%0d]: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        n_run++;
        if (a1_o !== e.a[0] || b1_o !== e.b[0]) begin
          n_fail++;
          $display("FAIL swap[%0d]: got (%0b,%0b) required (%0b,%0b)", i, a1_o, b1_o, e.a[0], e.b[0]);
        end
      end
      n_run++;
      if (a1_o === b1_o) begin
        n_fail++;
        $display("FAIL swap_distinct[%0d]: got a_o=b_o=%0b required a_o!=b_o", i, a1_o);
      end
    end
  endtask

  task automatic test_input_ignored();
    a1 = 1'b0; b1 = 1'b1;
    push1(4'd1, 4'd0, 8'd4);
    push1(4'd0, 4'd1, 8'd5);
    push1(4'd1, 4'd0, 8'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (q1.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL input_ignored[%0d]: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        n_run++;
        if (a1_o !== e.a[0] || b1_o !== e.b[0]) begin
          n_fail++;
          $display("FAIL input_ignored[%0d]: got (%0b,%0b) required (%0b,%0b)", i, a1_o, b1_o, e.a[0], e.b[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #5;
    rst1 = 1'b1;
    a1 = 1'b0; b1 = 1'b1;
    #1;
    n_run++;
    if ({a1_o, b1_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_now: got (%0b,%0b) required (0,0)", a1_o, b1_o);
    end
    @(posedge clk);
    #5;
    n_run++;
    if ({a1_o, b1_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_held: got (%0b,%0b) required (0,0)", a1_o, b1_o);
    end
    rst1 = 1'b0;
    push1(4'd0, 4'd1, 8'd0);
    push1(4'd1, 4'd0, 8'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (q1.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL async_reload[%0d]: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        n_run++;
        if (a1_o !== e.a[0] || b1_o !== e.b[0]) begin
          n_fail++;
          $display("FAIL async_reload[%0d]: got (%0b,%0b) required (%0b,%0b)", i, a1_o, b1_o, e.a[0], e.b[0]);
        end
      end
    end
  endtask

  task automatic test_equal_inputs();
    #2 rst1 = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    #2 rst1 = 1'b0;
    for (int i = 0; i < 4; i++) push1(4'd1, 4'd1, 8'(i));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (q1.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL equal[%0d]: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        n_run++;
        if (a1_o !== e.a[0] || b1_o !== e.b[0]) begin
          n_fail++;
          $display("FAIL equal[%0d]: got (%0b,%0b) required (%0b,%0b)", i, a1_o, b1_o, e.a[0], e.b[0]);
        end
      end
    end
  endtask

  task automatic test_reload();
    a2 = 4'd5; b2 = 4'd9;
    rst2 = 1'b0;
    push2(4'd5, 4'd9, 8'd0);
    push2(4'd9, 4'd5, 8'd1);
    push2(4'd5, 4'd9, 8'd2);
    push2(4'd9, 4'd5, 8'd3);
    push2(4'd2, 4'd7, 8'd0);
    push2(4'd7, 4'd2, 8'd1);
    push2(4'd2, 4'd7, 8'd2);
    push2(4'd7, 4'd2, 8'd3);
    push2(4'd2, 4'd7, 8'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) begin
        a2 = 4'd2; b2 = 4'd7;
      end
      if (q2.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL reload[%0d]: scoreboard empty", i);
      end else begin
        e = q2.pop_front();
        n_run++;
        if (a2_o !== e.a || b2_o !== e.b) begin
          n_fail++;
          $display("FAIL reload[%0d]: got (%0d,%0d) required (%0d,%0d)", i, a2_o, b2_o, e.a, e.b);
        end
`ifdef NONBLOCKING_SWAP_CNT_EN
        n_run++;
        if (cnt2 !== e.cnt) begin
          n_fail++;
          $display("FAIL reload_cnt[%0d]: got %0d required %0d", i, cnt2, e.cnt);
        end
`endif
      end
    end
  endtask

`ifdef NONBLOCKING_SWAP_CNT_EN
  task automatic test_counter();
    #2 rst1 = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    #2 rst1 = 1'b0;
    push1(4'd1, 4'd0, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      if (i % 2 == 1) push1(4'd0, 4'd1, 8'(i % 256));
      else            push1(4'd1, 4'd0, 8'(i % 256));
    end
    for (int i = 0; i <= 300; i++) begin
      tick();
      if (q1.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL counter[%0d]: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        n_run++;
        if (cnt1 !== e.cnt || a1_o !== e.a[0] || b1_o !== e.b[0]) begin
          n_fail++;
          $display("FAIL counter[%0d]: got cnt=%0d (%0b,%0b) required cnt=%0d (%0b,%0b)",
                   i, cnt1, a1_o, b1_o, e.cnt, e.a[0], e.b[0]);
        end
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_swap();
    test_input_ignored();
    test_async_reset();
    test_equal_inputs();
    test_reload();
`ifdef NONBLOCKING_SWAP_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
